alu_seq_exec: RTL and testbench

Multi-cycle execute-stage ALU sitting directly downstream of the ALU controller. It consumes the 4-bit `Operation` code plus two operands through a valid/ready handshake. Logic, arithmetic and compare operations complete in one cycle; shifts run on an iterative 1-bit-per-cycle shifter. The registered result is held until the downstream stage takes it.

---
 rtl/alu_seq_exec.sv | 131 +++++++++++++
 tb/tb_alu_seq_exec.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: logic, arithmetic and compare ops finish in one cycle,
// shifts iterate one bit per cycle. The registered result is held until the consumer takes it.
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_shReg;
  logic [3:0]       r_op;
  logic [4:0]       r_count;

  logic             w_accept;
  logic             w_isShift;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_aluOut;
  logic [WIDTH-1:0] w_shiftNext;

  assign in_ready  = (r_state == IDLE) && !flush;
  assign out_valid = (r_state == DONE);
  assign ALUResult = r_result;
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = SrcB[4:0];
  assign w_isShift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  always_comb begin
    w_aluOut = '0;
    case (Operation)
      OP_AND:  w_aluOut = SrcA & SrcB;
      OP_OR:   w_aluOut = SrcA | SrcB;
      OP_ADD:  w_aluOut = SrcA + SrcB;
      OP_XOR:  w_aluOut = SrcA ^ SrcB;
      OP_SUB:  w_aluOut = SrcA - SrcB;
      OP_BEQ:  w_aluOut = {{(WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLT:  w_aluOut = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: w_aluOut = '0;
    endcase
  end

  // One step of the iterative shifter, driven by the op latched at acceptance.
  always_comb begin
    w_shiftNext = r_shReg;
    case (r_op)
      OP_SLL:  w_shiftNext = {r_shReg[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shiftNext = {1'b0, r_shReg[WIDTH-1:1]};
      OP_SRA:  w_shiftNext = {r_shReg[WIDTH-1], r_shReg[WIDTH-1:1]};
      default: w_shiftNext = r_shReg;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isShift && (w_shamt != 5'd0)) w_nextState = SHIFT;
          else                                w_nextState = DONE;
        end
      end
      SHIFT:   if (r_count == 5'd1) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  // The final shift step writes the result directly, so shamt=k completes k cycles after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_shReg  <= '0;
      r_op     <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_nextState;
      if (flush) begin
        r_count <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (!w_isShift) begin
                r_result <= w_aluOut;
              end else if (w_shamt == 5'd0) begin
                r_result <= SrcA;
              end else begin
                r_shReg <= SrcA;
                r_op    <= Operation;
                r_count <= w_shamt;
              end
            end
          end
          SHIFT: begin
            r_shReg <= w_shiftNext;
            r_count <= r_count - 5'd1;
            if (r_count == 5'd1) r_result <= w_shiftNext;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, random ops against a
// plain-arithmetic reference model, and hand sequences for flush/reset/backpressure.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] heldResult;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult)
  );

  // Reference ALU written straight from the op table, shifts done in one step.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    int sh;
    sa = a;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return a - b;
      4'd7:    return sa >>> sh;
      4'd8:    return (a == b) ? 32'd1 : 32'd0;
      4'd12:   return (sa < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op, count cycles to out_valid, optionally stall in DONE, then hand the result off.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int expLat,
                               input int holdCycles);
    int   cycles;
    logic busyOk;
    logic stable;
    @(negedge clk);
    checkOutput({name, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    cycles = 1;
    #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
    busyOk = 1'b1;
    while (cycles < 80) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) busyOk = 1'b0;
      @(posedge clk);
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({name, " in_ready low while busy"}, {31'b0, busyOk}, 32'd1);
    checkOutput({name, " result"}, ALUResult, expRes);
    checkOutput({name, " in_ready low in DONE"}, {31'b0, in_ready}, 32'd0);
    if (holdCycles > 0) begin
      stable = 1'b1;
      repeat (holdCycles) begin
        @(negedge clk);
        if (!out_valid || ALUResult !== expRes || in_ready) stable = 1'b0;
      end
      checkOutput({name, " stable under backpressure"}, {31'b0, stable}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, " out_valid after handoff"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, " in_ready after handoff"}, {31'b0, in_ready}, 32'd1);
    heldResult = expRes;
  endtask

  initial begin
    logic [3:0]  opList[10];
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        quiet;

    vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[1]  = '{4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1};
    vecs[2]  = '{4'b1100, 32'h80000000, 32'h00000001, 32'h00000001, 1};
    vecs[3]  = '{4'b1000, 32'h00001234, 32'h00001234, 32'h00000001, 1};
    vecs[4]  = '{4'b0011, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1};
    vecs[5]  = '{4'b0111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32};
    vecs[6]  = '{4'b0101, 32'h80000000, 32'd4,        32'h08000000, 5};
    vecs[7]  = '{4'b0100, 32'h00000001, 32'd0,        32'h00000001, 1};
    vecs[8]  = '{4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1};
    vecs[9]  = '{4'b0001, 32'hFF000000, 32'h000000FF, 32'hFF0000FF, 1};
    vecs[10] = '{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1};
    vecs[11] = '{4'b1100, 32'h00000001, 32'h80000000, 32'h00000000, 1};
    vecs[12] = '{4'b0111, 32'h80000000, 32'hFFFFFFE3, 32'hF0000000, 4};

    opList = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};

    // Reset with random junk on the inputs.
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'($urandom); Operation = 4'($urandom);
    SrcA = $urandom; SrcB = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset ALUResult", ALUResult, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    heldResult = 32'd0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expRes, vecs[i].expLat, 0);
    end

    applyStimulus("backpressure", 4'b0010, 32'h11111111, 32'h22222222, 32'h33333333, 1, 5);

    // Flush while an SRL by 20 has 10 steps left.
    @(negedge clk);
    Operation = 4'b0101; SrcA = 32'hCAFEF00D; SrcB = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    checkOutput("flush in_ready gated", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush shift out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush shift in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush shift ALUResult kept", ALUResult, heldResult);
    quiet = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    checkOutput("flush shift no late result", {31'b0, quiet}, 32'd1);

    // Flush alongside in_valid in IDLE: the op must not be taken.
    @(negedge clk);
    Operation = 4'b0010; SrcA = 32'd100; SrcB = 32'd23; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush idle not accepted", {31'b0, out_valid}, 32'd0);
    checkOutput("flush idle ALUResult kept", ALUResult, heldResult);

    // Flush in DONE with out_ready high drops the result.
    @(negedge clk);
    Operation = 4'b0011; SrcA = 32'hA5A5A5A5; SrcB = 32'h0000FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush done pre out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("flush done pre result", ALUResult, 32'hA5A55A5A);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush done out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush done in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush done ALUResult kept", ALUResult, 32'hA5A55A5A);

    // Reset (with flush also high) during an SLL by 20, seven cycles in.
    @(negedge clk);
    Operation = 4'b0100; SrcA = 32'h00000003; SrcB = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1; flush = 1'b0;
    @(negedge clk);
    checkOutput("reset mid-shift out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset mid-shift ALUResult", ALUResult, 32'd0);
    checkOutput("reset mid-shift in_ready", {31'b0, in_ready}, 32'd1);
    heldResult = 32'd0;
    applyStimulus("post-reset sll", 4'b0100, 32'h00000081, 32'd5, refAlu(4'b0100, 32'h00000081, 32'd5),
                  refLatency(4'b0100, 32'd5), 0);

    // Random ops checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : opList[$urandom_range(0, 9)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, refAlu(rop, ra, rb),
                    refLatency(rop, rb), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
